// File: rtl/rat_pkg.sv
// Shared constants and types for the register alias table and its branch checkpoints.
package rat_pkg;
  localparam int NUM_ARCH   = 32;
  localparam int TAG_W      = 6;
  localparam int NUM_CKPT   = 8;
  localparam int CKPT_IDX_W = 3;
  localparam int ARCH_W     = 5;

  typedef logic [ARCH_W-1:0]     arch_idx_t;
  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [CKPT_IDX_W-1:0] ckpt_idx_t;

  typedef struct packed {
    logic busy;
    tag_t tag;
  } rat_entry_t;

  typedef rat_entry_t [NUM_ARCH-1:0] rat_table_t;

  // Writeback snoop: a producer tag only clears busy if it is still the current mapping.
  function automatic rat_table_t wb_clear(input rat_table_t t, input logic v,
                                          input arch_idx_t rd, input tag_t tag);
    rat_table_t r;
    r = t;
    if (v && r[rd].busy && (r[rd].tag == tag)) r[rd].busy = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/rat_ckpt_if.sv
// Rename / writeback / branch-buffer bundle for rat_ckpt. Perf ports exist only with RAT_CKPT_PERF_EN.
interface rat_ckpt_if;
  import rat_pkg::*;

  logic                rn_valid;
  arch_idx_t           rn_rd;
  tag_t                rn_tag;
  arch_idx_t           rs1_addr;
  arch_idx_t           rs2_addr;
  logic                rs1_busy;
  tag_t                rs1_tag;
  logic                rs2_busy;
  tag_t                rs2_tag;
  logic                wb_valid;
  arch_idx_t           wb_rd;
  tag_t                wb_tag;
  logic                copy_rat;
  ckpt_idx_t           copy_idx;
  logic                paste_rat;
  ckpt_idx_t           paste_idx;
  logic                rel_valid;
  ckpt_idx_t           rel_idx;
  logic [NUM_CKPT-1:0] ckpt_valid;
  logic                restore_done;
  logic                paste_err;
`ifdef RAT_CKPT_PERF_EN
  logic [15:0]         perf_copy_cnt;
  logic [15:0]         perf_restore_cnt;
`endif

  modport master (
    output rn_valid, rn_rd, rn_tag, rs1_addr, rs2_addr, wb_valid, wb_rd, wb_tag,
           copy_rat, copy_idx, paste_rat, paste_idx, rel_valid, rel_idx,
    input  rs1_busy, rs1_tag, rs2_busy, rs2_tag, ckpt_valid, restore_done, paste_err
`ifdef RAT_CKPT_PERF_EN
  , input  perf_copy_cnt, perf_restore_cnt
`endif
  );

  modport slave (
    input  rn_valid, rn_rd, rn_tag, rs1_addr, rs2_addr, wb_valid, wb_rd, wb_tag,
           copy_rat, copy_idx, paste_rat, paste_idx, rel_valid, rel_idx,
    output rs1_busy, rs1_tag, rs2_busy, rs2_tag, ckpt_valid, restore_done, paste_err
`ifdef RAT_CKPT_PERF_EN
  , output perf_copy_cnt, perf_restore_cnt
`endif
  );
endinterface

// File: rtl/rat_ckpt_bank.sv
// Checkpoint snapshot array: one full RAT copy per in-flight branch, kept coherent with writeback.
module rat_ckpt_bank
  import rat_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  ckpt_idx_t           wr_idx,
  input  rat_table_t          wr_data,
  input  logic [NUM_CKPT-1:0] snoop_mask,
  input  logic                wb_valid,
  input  arch_idx_t           wb_rd,
  input  tag_t                wb_tag,
  input  ckpt_idx_t           rd_idx,
  output rat_table_t          rd_data
);
  rat_table_t ckpt_q [NUM_CKPT];

  // NOTE: this array is reset explicitly because restored snapshots must read as all-idle after rst;
  // state is only ever updated with non-blocking assignments so every slot sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (wr_en && (wr_idx == CKPT_IDX_W'(i))) ckpt_q[i] <= wr_data;
        else if (snoop_mask[i]) ckpt_q[i] <= wb_clear(ckpt_q[i], wb_valid, wb_rd, wb_tag);
      end
    end
  end

  assign rd_data = ckpt_q[rd_idx];
endmodule

// File: rtl/rat_ckpt.sv
// Live register alias table with paste > copy > rename priority. Optional perf counters: RAT_CKPT_PERF_EN.
module rat_ckpt
  import rat_pkg::*;
(
  input logic        clk,
  input logic        rst,
  rat_ckpt_if.slave  bus
);
  rat_table_t          rat_q, rat_d, rat_wb, rat_rn, ckpt_rd;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic                restore_done_q, paste_err_q;
  logic                paste_ok, copy_ok;

  assign paste_ok = bus.paste_rat && valid_q[bus.paste_idx];
  assign copy_ok  = bus.copy_rat && !bus.paste_rat;

  rat_ckpt_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (copy_ok),
    .wr_idx     (bus.copy_idx),
    .wr_data    (rat_rn),
    .snoop_mask (valid_q),
    .wb_valid   (bus.wb_valid),
    .wb_rd      (bus.wb_rd),
    .wb_tag     (bus.wb_tag),
    .rd_idx     (bus.paste_idx),
    .rd_data    (ckpt_rd)
  );

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    rat_wb = wb_clear(rat_q, bus.wb_valid, bus.wb_rd, bus.wb_tag);
    rat_rn = rat_wb;
    if (bus.rn_valid && (bus.rn_rd != '0)) rat_rn[bus.rn_rd] = '{busy: 1'b1, tag: bus.rn_tag};
    rat_d = rat_rn;
    // Any paste cycle is a flush: the same-cycle rename is wrong-path even if the slot was invalid.
    if (bus.paste_rat) rat_d = paste_ok ? wb_clear(ckpt_rd, bus.wb_valid, bus.wb_rd, bus.wb_tag)
                                        : rat_wb;
  end

  always_comb begin
    valid_d = valid_q;
    if (paste_ok) begin
      valid_d = '0;
    end else if (!bus.paste_rat) begin
      if (bus.rel_valid) valid_d[bus.rel_idx]  = 1'b0;
      if (bus.copy_rat)  valid_d[bus.copy_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rat_q          <= '0;
      valid_q        <= '0;
      restore_done_q <= 1'b0;
      paste_err_q    <= 1'b0;
    end else begin
      rat_q          <= rat_d;
      valid_q        <= valid_d;
      restore_done_q <= paste_ok;
      paste_err_q    <= bus.paste_rat && !valid_q[bus.paste_idx];
    end
  end

  assign bus.rs1_busy     = (bus.rs1_addr != '0) && rat_q[bus.rs1_addr].busy;
  assign bus.rs1_tag      = (bus.rs1_addr != '0) ? rat_q[bus.rs1_addr].tag : '0;
  assign bus.rs2_busy     = (bus.rs2_addr != '0) && rat_q[bus.rs2_addr].busy;
  assign bus.rs2_tag      = (bus.rs2_addr != '0) ? rat_q[bus.rs2_addr].tag : '0;
  assign bus.ckpt_valid   = valid_q;
  assign bus.restore_done = restore_done_q;
  assign bus.paste_err    = paste_err_q;

`ifdef RAT_CKPT_PERF_EN
  logic [15:0] perf_copy_q, perf_restore_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_copy_q    <= '0;
      perf_restore_q <= '0;
    end else begin
      if (copy_ok && (perf_copy_q != 16'hFFFF))     perf_copy_q    <= perf_copy_q + 16'd1;
      if (paste_ok && (perf_restore_q != 16'hFFFF)) perf_restore_q <= perf_restore_q + 16'd1;
    end
  end

  assign bus.perf_copy_cnt    = perf_copy_q;
  assign bus.perf_restore_cnt = perf_restore_q;
`endif
endmodule

// File: doc/rat_ckpt.md
Name: rat_ckpt

Overview:
- Register alias table (RAT) with branch checkpoint storage for the out-of-order RISC-V core.
- Sits directly downstream of the branch buffer. It consumes Copy_RAT/tail_num to snapshot the RAT when a jump or branch is renamed, and Paste_RAT/head_num to restore the RAT on mispredict.
- Serves source-tag lookup to rename/dispatch and snoops writeback to clear busy bits.

Parameters:
- NUM_ARCH, 32, architectural register count (x0..x31).
- TAG_W, 6, physical/ROB tag width.
- NUM_CKPT, 8, checkpoint slots; must match branch buffer depth.
- CKPT_IDX_W, 3, log2(NUM_CKPT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rn_valid  in  1  rename write this cycle
- rn_rd  in  5  destination architectural reg
- rn_tag  in  TAG_W  newly allocated tag for rn_rd
- rs1_addr  in  5  source 1 lookup
- rs2_addr  in  5  source 2 lookup
- rs1_busy  out  1  source 1 pending
- rs1_tag  out  TAG_W  source 1 producer tag
- rs2_busy  out  1  source 2 pending
- rs2_tag  out  TAG_W  source 2 producer tag
- wb_valid  in  1  writeback broadcast
- wb_rd  in  5  writeback arch reg
- wb_tag  in  TAG_W  writeback tag
- copy_rat  in  1  snapshot request (from branch buffer Copy_RAT)
- copy_idx  in  CKPT_IDX_W  slot (tail_num)
- paste_rat  in  1  restore request (Paste_RAT)
- paste_idx  in  CKPT_IDX_W  slot (head_num)
- rel_valid  in  1  release slot (branch resolved correct)
- rel_idx  in  CKPT_IDX_W  slot to release
- ckpt_valid  out  NUM_CKPT  slot-occupied mask
- restore_done  out  1  one-cycle pulse after a restore is applied
- paste_err  out  1  one-cycle pulse: paste to an invalid slot

Behaviour:
- Entry = {busy, tag}. busy=0 means the value lives in the architectural register file and tag is don't-care.
- Reset (async):
  - All RAT entries, all checkpoint entries and ckpt_valid are 0.
  - restore_done=0, paste_err=0.
- Lookup is combinational from the current registered RAT. There is no bypass from a same-cycle rn write, because sources are read before the destination is renamed. x0 always reads busy=0, tag=0.
- Rename: on posedge with rn_valid and rn_rd!=0, RAT[rn_rd] <= {1, rn_tag}. Writes to rn_rd=0 are ignored.
- Writeback: on wb_valid, if RAT[wb_rd].busy && RAT[wb_rd].tag==wb_tag, clear busy. The same match-and-clear applies to every valid checkpoint slot.
- Same cycle, same reg, rename and wb: rename wins (the new mapping is kept busy).
- Copy: on copy_rat, ckpt[copy_idx] <= next-state RAT, i.e. including the same-cycle rename write and wb clears. ckpt_valid[copy_idx] <= 1. Copying into an already-valid slot overwrites it.
- Paste: on paste_rat with ckpt_valid[paste_idx]=1:
  - RAT <= ckpt[paste_idx], with the same-cycle wb clear applied.
  - Any same-cycle rn write is discarded as wrong-path.
  - All ckpt_valid bits are cleared.
  - restore_done=1 next cycle.
- Paste to an invalid slot: RAT unchanged, paste_err=1 for one cycle.
- Priority in one cycle: paste > copy > rename.
  - copy_rat is ignored in a paste cycle.
  - rel_valid is ignored in a paste cycle.
- Release: rel_valid clears ckpt_valid[rel_idx]. The slot data is left unchanged. Copy and release of the same idx in one cycle: copy wins.
- Latency: every update is visible to lookup on the cycle after the clock edge.
- Reset mid-restore: all state returns to the reset values; no pending pulses survive.

Optional Feature:
- Macro: RAT_CKPT_PERF_EN.
- Defined: adds outputs perf_copy_cnt[15:0] and perf_restore_cnt[15:0]. These are saturating counts of accepted copies and accepted (valid-slot) pastes, reset to 0 by rst.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Decomposition:
- Package rat_pkg holds:
  - NUM_ARCH, TAG_W, NUM_CKPT and CKPT_IDX_W constants.
  - rat_entry_t struct {busy, tag}.
  - rat_table_t array type.
- Sub-module rat_ckpt_bank: the NUM_CKPT snapshot array with write, wb-snoop and read-out. rat_ckpt owns the live RAT and the priority logic.

Test Plan:
- Rename x5->tag 12, then lookup rs1=x5 -> busy=1, tag=12. Lookup x0 -> busy=0.
- Rename x5->12 with copy_rat idx 2 in the same cycle. Rename x5->20. Paste idx 2 -> next cycle x5 reads tag 12, restore_done=1, ckpt_valid=0.
- Checkpoint slot 1 holding x7->9. wb x7 tag 9. Paste idx 1 -> x7 busy=0.
- wb x3 tag 4 while RAT[x3]=tag 6 -> x3 stays busy with tag 6.
- Paste idx 5 with ckpt_valid[5]=0 -> paste_err pulse, RAT unchanged.
- Same cycle: paste idx 0, copy idx 3, rename x9->30 -> RAT equals ckpt[0], x9 not remapped, ckpt_valid=0.
